// File: rtl/sram_1rw_ctrl_pkg.sv
// Shared types and default widths for the single-port 1RW SRAM initiator controller.
// The INIT state is only used when SRAM_INIT_EN is defined.
package sram_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } sram_req_t;

    // Bits needed to hold an occupancy count of 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_1rw_ctrl_rsp_fifo.sv
// Synchronous response FIFO with simultaneous push/pop and occupancy count.
// Read data is presented from the head entry while non-empty.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_wdata,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_rdata,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [cnt_width(DEPTH)-1:0] o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= CNT_W'(r_count + 1'b1);
                2'b01:   r_count <= CNT_W'(r_count - 1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/sram_1rw_ctrl.sv
// Initiator-side controller for a single-port 1RW SRAM macro with a credit-limited read path.
// Define SRAM_INIT_EN to zero-fill the macro after reset before accepting requests.
module sram_1rw_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] sram_a,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);

    localparam int unsigned CNT_W = cnt_width(RSP_DEPTH);
    localparam int unsigned OUT_W = CNT_W + 1;

    logic              w_accept;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [OUT_W-1:0]  w_credit_used;
    logic              w_init_done;

    logic              r_p0_rd;
    logic              r_p1_rd;
    logic              r_csb;
    logic              r_web;
    logic              r_oeb;
    logic [ADDR_W-1:0] r_a;
    logic [DATA_W-1:0] r_i;

    logic              w_csb_nxt;
    logic              w_web_nxt;
    logic [ADDR_W-1:0] w_a_nxt;
    logic [DATA_W-1:0] w_i_nxt;

`ifdef SRAM_INIT_EN
    ctrl_state_e       r_state;
    ctrl_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_init_addr;
    logic [ADDR_W-1:0] w_init_addr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= INIT;
            r_init_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_addr <= w_init_addr_nxt;
        end
    end

    assign w_init_done = (r_state == RUN);
`else
    assign w_init_done = 1'b1;
`endif

    // Reads in the pin/macro pipeline plus queued responses, net of this cycle's pop.
    assign w_pop         = rsp_valid && rsp_ready;
    assign w_credit_used = OUT_W'(r_p0_rd) + OUT_W'(r_p1_rd) + OUT_W'(w_count) - OUT_W'(w_pop);
    assign req_ready     = w_init_done && (w_credit_used < OUT_W'(RSP_DEPTH));
    assign w_accept      = req_valid && req_ready;

    // Next pin values: idle deselects, init sweep writes zero, accepted requests drive the macro.
    always_comb begin
        w_csb_nxt = 1'b1;
        w_web_nxt = 1'b1;
        w_a_nxt   = r_a;
        w_i_nxt   = r_i;
`ifdef SRAM_INIT_EN
        w_state_nxt     = r_state;
        w_init_addr_nxt = r_init_addr;
        case (r_state)
            INIT: begin
                w_csb_nxt       = 1'b0;
                w_web_nxt       = 1'b0;
                w_a_nxt         = r_init_addr;
                w_i_nxt         = '0;
                w_init_addr_nxt = ADDR_W'(r_init_addr + 1'b1);
                if (r_init_addr == '1) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
            end
        endcase
`endif
        if (w_accept) begin
            w_csb_nxt = 1'b0;
            w_web_nxt = ~req_we;
            w_a_nxt   = req_addr;
            if (req_we) begin
                w_i_nxt = req_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_oeb   <= 1'b1;
            r_a     <= '0;
            r_i     <= '0;
            r_p0_rd <= 1'b0;
            r_p1_rd <= 1'b0;
        end else begin
            r_csb   <= w_csb_nxt;
            r_web   <= w_web_nxt;
            r_a     <= w_a_nxt;
            r_i     <= w_i_nxt;
            r_p0_rd <= w_accept && !req_we;
            r_p1_rd <= r_p0_rd;
            r_oeb   <= ~r_p0_rd;
        end
    end

    // Macro output is valid the cycle after it samples a read; capture it then.
    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_p1_rd),
        .i_wdata (sram_o),
        .i_pop   (w_pop),
        .o_rdata (rsp_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    a_rsp_no_overflow: assert property (@(posedge clk) disable iff (rst) !(r_p1_rd && w_full && !w_pop));

    assign rsp_valid = ~w_empty;
    assign init_done = w_init_done;
    assign sram_a    = r_a;
    assign sram_csb  = r_csb;
    assign sram_web  = r_web;
    assign sram_oeb  = r_oeb;
    assign sram_i    = r_i;

endmodule
